gen_context_pkt_mc: RTL and testbench
=====================================

# gen_context_pkt_mc

Multi-channel VITA-49 context/error packet generator for the DSP/VRT path. Each of NUM_CHAN sources raises a trigger with a 32-bit message. The block snapshots the message and the VITA time per channel, then arbitrates round-robin among pending channels. It emits one complete context packet per trigger on a single 36-bit ll8-style stream toward the protocol engine, with per-channel sequence numbers, overrun counting and a sent pulse.

## Interface
Parameters:
- NUM_CHAN, 4: number of trigger sources, 1..8.
- PROT_ENG_FLAGS, 1: 1 prepends the protocol-engine word (7-word packet); 0 gives a 6-word packet.
- PORT_SEL, 0: 15-bit value placed in the protocol-engine word.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; drops all pending triggers and zeroes drop counters; any packet in flight completes.
- trigger  in  NUM_CHAN  one-cycle request per channel.
- message  in  32*NUM_CHAN  per-channel message, sampled with trigger.
- streamid  in  32*NUM_CHAN  per-channel stream ID, sampled at grant.
- seqnum  in  32*NUM_CHAN  per-channel flow-control word, sampled at grant.
- vita_time  in  64  shared time, sampled with trigger.
- data_o  out  36  [31:0] payload, [32] SOF, [33] EOF, [35:34]=0.
- src_rdy_o  out  1  data_o valid.
- dst_rdy_i  in  1  downstream accepts.
- sent  out  NUM_CHAN  one-cycle pulse when that channel's EOF word transfers.
- drop_cnt  out  8*NUM_CHAN  per-channel saturating overrun count.
- busy  out  1  high when any channel is pending or a packet is in flight.

## Operation
- Per channel: pending flag plus capture registers msg_q[31:0] and time_q[63:0].
- trigger[i] with pending[i]=0: set pending, capture message[i] and vita_time.
- trigger[i] with pending[i]=1: keep the first capture; drop_cnt[i] increments and saturates at 255.
- States: IDLE, PROT_ENG, HEADER, STREAMID, TICS, TICS2, MESSAGE, FLOWCTRL, DONE.
- In IDLE with any pending: grant the first pending channel at or after last_grant+1, modulo NUM_CHAN.
  - Copy its captures, streamid and seqnum into working registers.
  - Clear its pending flag and record cur_chan.
  - Go to PROT_ENG if PROT_ENG_FLAGS, else HEADER.
- Word states advance only on a transfer (src_rdy_o & dst_rdy_i). FLOWCTRL goes to DONE; DONE goes to IDLE unconditionally and increments seqno[cur_chan].
- Words, in order:
  - PROT_ENG: {01 in [33:32], PORT_SEL[14:0], 1'b1, 16'd24 or 16'd28 matching total payload bytes of the VITA part}; with PROT_ENG_FLAGS=1 the VITA part is 24 bytes, so 16'd24.
  - HEADER: [31:20]=12'h501, [19:16]=seqno[cur_chan], [15:0]=16'd6; SOF set here only if PROT_ENG_FLAGS=0.
  - STREAMID: working streamid.
  - TICS: time_q[63:32].
  - TICS2: time_q[31:0].
  - MESSAGE: the captured msg_q, never the live input.
  - FLOWCTRL: working seqnum, EOF set.
- src_rdy_o = state not in {IDLE, DONE}. data_o is a pure function of state and the working registers, and holds stable while stalled.
- seqno: 4 bits per channel, wraps 15 to 0.
- clear: pending and drop_cnt cleared; state machine, seqno and last_grant unaffected.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE, pending=0, seqno=0, drop_cnt=0, last_grant=NUM_CHAN-1 (ch0 has priority first), src_rdy_o=0, sent=0, busy=0, data_o=0.
- Trigger sampled at edge k sets pending after k. Grant occurs at edge k+1. src_rdy_o is high after k+1, so the first word is valid 2 cycles after trigger assertion.
- With dst_rdy_i held high, a 7-word packet occupies 7 consecutive beats. DONE adds 1 idle cycle, so back-to-back packets are separated by 2 cycles of src_rdy_o=0 (DONE, IDLE).
- sent[cur_chan] is a registered pulse, high for the cycle after the EOF transfer.
- Grant and a new trigger on the same channel in the same cycle: the grant takes the old capture; the new trigger sets pending with the new capture; no drop counted.
- A trigger on the channel currently transmitting is accepted as a new pending entry.
- clear and trigger in the same cycle: clear wins and the trigger is discarded.

## Test plan
- NUM_CHAN=4, PROT_ENG_FLAGS=1, PORT_SEL=3: trigger ch2 with message=0xDEADBEEF, vita_time=0x0000_0001_0000_0020, dst_rdy_i=1 -> 7 words.
  - Word0 = {01, 15'd3, 1, 16'd24}.
  - Header = 0x5010_0006.
  - TICS = 0x1, TICS2 = 0x20, MESSAGE = 0xDEADBEEF.
  - EOF on word 7; sent[2] pulses once.
- Triggers on ch0..ch3 in the same cycle -> packets emitted in order ch0, ch1, ch2, ch3; each header seqno=0; a second round gives seqno=1 each.
- Trigger ch1 three times before its grant -> one packet carrying the first message; drop_cnt[1]=2. Then 300 overruns -> drop_cnt[1]=255.
- dst_rdy_i toggled 1010… mid-packet -> data_o stable while stalled, no word skipped or duplicated; change the message input during the stall -> the MESSAGE word is unchanged.
- 17 triggers on ch0 -> header seqno sequence 0..15, then 0.
- reset_n deasserted mid-packet (at the TICS word) -> src_rdy_o=0 immediately; after release the next trigger yields a full packet with seqno=0. clear mid-packet -> the current packet completes and pending triggers are lost.

Source files
------------

// File: rtl/gen_context_pkt_mc.sv
// gen_context_pkt_mc
// Multi-channel VITA-49 context/error packet generator. Each channel raises a
// one-cycle trigger with a 32-bit message. The block captures the message and
// the VITA time for that channel. It then picks among pending channels
// round-robin and sends one complete context packet per trigger on a 36-bit
// ll8-style stream.
//
// Ports
//   clk        sole clock
//   reset_n    asynchronous active-low reset
//   clear      sync: drop pending triggers, zero drop counters
//   trigger    per-channel one-cycle request
//   message    per-channel 32-bit message, captured with trigger
//   streamid   per-channel stream ID, captured at grant
//   seqnum     per-channel flow-control word, captured at grant
//   vita_time  shared 64-bit time, captured with trigger
//   data_o     {2'b0, EOF, SOF, payload[31:0]}
//   src_rdy_o  data_o valid
//   dst_rdy_i  downstream accepts
//   sent       per-channel pulse, cycle after the EOF transfer
//   drop_cnt   per-channel saturating overrun count (8 bits each)
//   busy       any channel pending or a packet in flight
//
// state    | meaning
// IDLE     | waiting for a pending channel; grants on entry
// PROT_ENG | protocol-engine word (SOF)
// HEADER   | VITA header with 4-bit per-channel sequence number
// STREAMID | stream ID captured at grant
// TICS     | time, upper 32 bits
// TICS2    | time, lower 32 bits
// MESSAGE  | captured message
// FLOWCTRL | flow-control word (EOF)
// DONE     | one idle beat; bumps the channel sequence number
module gen_context_pkt_mc #(
  parameter int          NUM_CHAN       = 4,
  parameter int          PROT_ENG_FLAGS = 1,
  parameter logic [14:0] PORT_SEL       = 15'd0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [NUM_CHAN-1:0]    trigger,
  input  logic [32*NUM_CHAN-1:0] message,
  input  logic [32*NUM_CHAN-1:0] streamid,
  input  logic [32*NUM_CHAN-1:0] seqnum,
  input  logic [63:0]            vita_time,
  output logic [35:0]            data_o,
  output logic                   src_rdy_o,
  input  logic                   dst_rdy_i,
  output logic [NUM_CHAN-1:0]    sent,
  output logic [8*NUM_CHAN-1:0]  drop_cnt,
  output logic                   busy
);

  localparam int            CW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHAN - 1);
  localparam logic          HDR_SOF = (PROT_ENG_FLAGS == 0);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_PROT_ENG = 4'd1;
  localparam logic [3:0] ST_HEADER   = 4'd2;
  localparam logic [3:0] ST_STREAMID = 4'd3;
  localparam logic [3:0] ST_TICS     = 4'd4;
  localparam logic [3:0] ST_TICS2    = 4'd5;
  localparam logic [3:0] ST_MESSAGE  = 4'd6;
  localparam logic [3:0] ST_FLOWCTRL = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  logic [3:0]          state_q, state_d;
  logic [NUM_CHAN-1:0] pending_q;
  logic [31:0]         msg_q   [NUM_CHAN];
  logic [63:0]         time_q  [NUM_CHAN];
  logic [7:0]          drop_q  [NUM_CHAN];
  logic [3:0]          seqno_q [NUM_CHAN];
  logic [CW-1:0]       last_grant_q, cur_chan_q;
  logic [31:0]         wk_msg_q, wk_sid_q, wk_seq_q;
  logic [63:0]         wk_time_q;
  logic [NUM_CHAN-1:0] sent_q;

  logic                xfer;
  logic                gnt_valid;
  logic [CW-1:0]       gnt_idx, rr_idx;

  assign src_rdy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign xfer      = src_rdy_o & dst_rdy_i;
  assign busy      = (|pending_q) || (state_q != ST_IDLE);
  assign sent      = sent_q;

  // Scan from the highest offset down so the nearest pending channel after
  // last_grant wins. A clear in the same cycle suppresses the grant because
  // the pending entry it would consume is being dropped.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int k = NUM_CHAN - 1; k >= 0; k--) begin
      rr_idx = CW'((int'(last_grant_q) + 1 + k) % NUM_CHAN);
      if (pending_q[rr_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
    if ((state_q != ST_IDLE) || clear) gnt_valid = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (gnt_valid) state_d = (PROT_ENG_FLAGS != 0) ? ST_PROT_ENG : ST_HEADER;
      ST_PROT_ENG: if (xfer) state_d = ST_HEADER;
      ST_HEADER:   if (xfer) state_d = ST_STREAMID;
      ST_STREAMID: if (xfer) state_d = ST_TICS;
      ST_TICS:     if (xfer) state_d = ST_TICS2;
      ST_TICS2:    if (xfer) state_d = ST_MESSAGE;
      ST_MESSAGE:  if (xfer) state_d = ST_FLOWCTRL;
      ST_FLOWCTRL: if (xfer) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_CH;
      cur_chan_q   <= '0;
      wk_msg_q     <= '0;
      wk_sid_q     <= '0;
      wk_seq_q     <= '0;
      wk_time_q    <= '0;
      sent_q       <= '0;
      for (int i = 0; i < NUM_CHAN; i++) seqno_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= '0;
      if (gnt_valid) begin
        last_grant_q <= gnt_idx;
        cur_chan_q   <= gnt_idx;
        wk_msg_q     <= msg_q[gnt_idx];
        wk_time_q    <= time_q[gnt_idx];
        wk_sid_q     <= streamid[32*int'(gnt_idx) +: 32];
        wk_seq_q     <= seqnum[32*int'(gnt_idx) +: 32];
      end
      if ((state_q == ST_FLOWCTRL) && xfer) sent_q[cur_chan_q] <= 1'b1;
      if (state_q == ST_DONE) seqno_q[cur_chan_q] <= seqno_q[cur_chan_q] + 4'd1;
    end
  end

  // A trigger on the channel being granted this cycle is a fresh entry, not
  // an overrun: the grant consumes the old capture via non-blocking reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        msg_q[i]  <= '0;
        time_q[i] <= '0;
        drop_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (clear) begin
          pending_q[i] <= 1'b0;
          drop_q[i]    <= '0;
        end else if (trigger[i] && (!pending_q[i] || (gnt_valid && (gnt_idx == CW'(i))))) begin
          pending_q[i] <= 1'b1;
          msg_q[i]     <= message[32*i +: 32];
          time_q[i]    <= vita_time;
        end else if (trigger[i]) begin
          if (drop_q[i] != 8'hFF) drop_q[i] <= drop_q[i] + 8'd1;
        end else if (gnt_valid && (gnt_idx == CW'(i))) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CHAN; i++) drop_cnt[8*i +: 8] = drop_q[i];
  end

  always_comb begin
    data_o = '0;
    case (state_q)
      ST_PROT_ENG: data_o = {2'b00, 2'b01, PORT_SEL, 1'b1, 16'd24};
      ST_HEADER:   data_o = {2'b00, 1'b0, HDR_SOF, 12'h501, seqno_q[cur_chan_q], 16'd6};
      ST_STREAMID: data_o = {4'b0000, wk_sid_q};
      ST_TICS:     data_o = {4'b0000, wk_time_q[63:32]};
      ST_TICS2:    data_o = {4'b0000, wk_time_q[31:0]};
      ST_MESSAGE:  data_o = {4'b0000, wk_msg_q};
      ST_FLOWCTRL: data_o = {2'b00, 2'b10, wk_seq_q};
      default:     data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_gen_context_pkt_mc.sv
module tb_gen_context_pkt_mc;

  localparam int          N        = 4;
  localparam logic [14:0] PORT_SEL = 15'd3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clear;
  logic [N-1:0]    trigger;
  logic [32*N-1:0] message, streamid, seqnum;
  logic [63:0]     vita_time;
  logic [35:0]     data_o;
  logic            src_rdy_o;
  logic            dst_rdy_i;
  logic [N-1:0]    sent;
  logic [8*N-1:0]  drop_cnt;
  logic            busy;

  always #5 clk = ~clk;

  gen_context_pkt_mc #(.NUM_CHAN(N), .PROT_ENG_FLAGS(1), .PORT_SEL(PORT_SEL)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .trigger(trigger),
    .message(message), .streamid(streamid), .seqnum(seqnum), .vita_time(vita_time),
    .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .sent(sent), .drop_cnt(drop_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Packet-level reference: per-channel captures, and the whole packet built
  // as a word list at grant time, then walked one word per transfer.
  bit          m_pend [N];
  logic [31:0] m_msg  [N];
  logic [63:0] m_time [N];
  int          m_drop [N];
  int          m_seq  [N];
  int          m_last, m_cur, m_phase, m_pos;  // phase: 0 idle, 1 sending, 2 gap beat
  logic [35:0] m_words [7];
  logic [N-1:0] m_sent;

  logic [35:0] rx_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_msg[i] = '0; m_time[i] = '0; m_drop[i] = 0; m_seq[i] = 0;
    end
    m_last = N - 1; m_cur = 0; m_phase = 0; m_pos = 0; m_sent = '0;
  endfunction

  function automatic bit model_busy();
    bit b = (m_phase != 0);
    for (int i = 0; i < N; i++) if (m_pend[i]) b = 1;
    return b;
  endfunction

  function automatic void model_grant(input int c);
    logic [63:0] t = m_time[c];
    m_words[0] = {2'b00, 2'b01, PORT_SEL, 1'b1, 16'd24};
    m_words[1] = {4'b0000, 12'h501, 4'(m_seq[c]), 16'd6};
    m_words[2] = {4'b0000, streamid[32*c +: 32]};
    m_words[3] = {4'b0000, t[63:32]};
    m_words[4] = {4'b0000, t[31:0]};
    m_words[5] = {4'b0000, m_msg[c]};
    m_words[6] = {4'b0010, seqnum[32*c +: 32]};
    m_pend[c] = 0; m_last = c; m_cur = c; m_phase = 1; m_pos = 0;
  endfunction

  function automatic void model_step();
    logic [N-1:0] nsent = '0;
    bit found = 0;
    if (m_phase == 1) begin
      if (dst_rdy_i) begin
        if (m_pos == 6) begin
          nsent[m_cur] = 1'b1;
          m_phase = 2;
        end
        m_pos++;
      end
    end else if (m_phase == 2) begin
      m_seq[m_cur] = (m_seq[m_cur] + 1) % 16;
      m_phase = 0;
    end else if (!clear) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_last + 1 + k) % N;
        if (!found && m_pend[c]) begin
          found = 1;
          model_grant(c);
        end
      end
    end
    m_sent = nsent;
    for (int i = 0; i < N; i++) begin
      if (clear) begin
        m_pend[i] = 0; m_drop[i] = 0;
      end else if (trigger[i]) begin
        if (m_pend[i]) begin
          if (m_drop[i] < 255) m_drop[i]++;
        end else begin
          m_pend[i] = 1; m_msg[i] = message[32*i +: 32]; m_time[i] = vita_time;
        end
      end
    end
  endfunction

  // One clock: compare at the falling edge, advance the model, return just
  // after the rising edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk);
    chk("src_rdy", src_rdy_o, m_phase == 1);
    chk("data", data_o, (m_phase == 1) ? m_words[m_pos] : 36'd0);
    chk("sent", sent, m_sent);
    chk("busy", busy, model_busy());
    for (int i = 0; i < N; i++) chk($sformatf("drop%0d", i), drop_cnt[8*i +: 8], m_drop[i]);
    if (src_rdy_o && dst_rdy_i) rx_q.push_back(data_o);
    if (!reset_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    bit ok = 0;
    for (int n = 0; n < maxc && !ok; n++) begin
      tick();
      if (!busy) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: busy still %0b after %0d cycles", busy, maxc);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; trigger = '0; clear = 1'b0; dst_rdy_i = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [N-1:0] trig;
    logic         dst;
    logic         rdy;
    logic [35:0]  data;
    logic [N-1:0] snt;
    logic         bsy;
  } vec_t;

  vec_t tv [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [35:0] w;

    tv[0]  = '{4'b0100, 1'b1, 1'b0, 36'h0_0000_0000, 4'b0000, 1'b0};
    tv[1]  = '{4'b0000, 1'b1, 1'b0, 36'h0_0000_0000, 4'b0000, 1'b1};
    tv[2]  = '{4'b0000, 1'b1, 1'b1, 36'h1_0007_0018, 4'b0000, 1'b1};
    tv[3]  = '{4'b0000, 1'b1, 1'b1, 36'h0_5010_0006, 4'b0000, 1'b1};
    tv[4]  = '{4'b0000, 1'b1, 1'b1, 36'h0_A5A5_0002, 4'b0000, 1'b1};
    tv[5]  = '{4'b0000, 1'b1, 1'b1, 36'h0_0000_0001, 4'b0000, 1'b1};
    tv[6]  = '{4'b0000, 1'b1, 1'b1, 36'h0_0000_0020, 4'b0000, 1'b1};
    tv[7]  = '{4'b0000, 1'b1, 1'b1, 36'h0_DEAD_BEEF, 4'b0000, 1'b1};
    tv[8]  = '{4'b0000, 1'b1, 1'b1, 36'h2_5EC0_0002, 4'b0000, 1'b1};
    tv[9]  = '{4'b0000, 1'b1, 1'b0, 36'h0_0000_0000, 4'b0100, 1'b1};
    tv[10] = '{4'b0000, 1'b1, 1'b0, 36'h0_0000_0000, 4'b0000, 1'b0};

    message = '0; vita_time = '0;
    for (int i = 0; i < N; i++) begin
      streamid[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      seqnum[32*i +: 32]   = 32'h5EC0_0000 + 32'(i);
    end
    model_reset();
    do_reset();

    // Single ch2 packet, cycle by cycle.
    message[64 +: 32] = 32'hDEAD_BEEF;
    vita_time = 64'h0000_0001_0000_0020;
    for (int r = 0; r < 11; r++) begin
      trigger = tv[r].trig; dst_rdy_i = tv[r].dst;
      #1;
      chk($sformatf("tv%0d_rdy", r), src_rdy_o, tv[r].rdy);
      chk($sformatf("tv%0d_data", r), data_o, tv[r].data);
      chk($sformatf("tv%0d_sent", r), sent, tv[r].snt);
      chk($sformatf("tv%0d_busy", r), busy, tv[r].bsy);
      tick();
    end

    // All four channels at once, two rounds.
    do_reset();
    for (int round = 0; round < 2; round++) begin
      rx_q.delete();
      trigger = 4'b1111; tick(); trigger = '0;
      drain(100);
      chk("rr_words", rx_q.size(), 28);
      for (int c = 0; c < N; c++) begin
        w = rx_q[7*c + 2];
        chk($sformatf("rr%0d_sid%0d", round, c), w, {4'b0, 32'hA5A5_0000 + 32'(c)});
        w = rx_q[7*c + 1];
        chk($sformatf("rr%0d_seq%0d", round, c), w[19:16], round);
      end
    end

    // Overruns on ch1 while ch0 is stalled.
    rx_q.delete();
    trigger = 4'b0001; tick(); trigger = '0; dst_rdy_i = 1'b0; tick();
    message[32 +: 32] = 32'h1111_1111; trigger = 4'b0010; tick();
    message[32 +: 32] = 32'h2222_2222; tick();
    message[32 +: 32] = 32'h3333_3333; tick();
    trigger = '0; tick();
    chk("drop1_after3", drop_cnt[15:8], 2);
    dst_rdy_i = 1'b1;
    drain(100);
    chk("ovr_words", rx_q.size(), 14);
    w = rx_q[9];  chk("ovr_sid", w, {4'b0, 32'hA5A5_0001});
    w = rx_q[12]; chk("ovr_first_msg", w, {4'b0, 32'h1111_1111});

    trigger = 4'b0001; tick(); trigger = '0; dst_rdy_i = 1'b0; tick();
    for (int i = 0; i < 301; i++) begin
      trigger = 4'b0010; message[32 +: 32] = $urandom; tick();
      if (i == 252) chk("drop1_254", drop_cnt[15:8], 254);
    end
    trigger = '0; tick();
    chk("drop1_sat", drop_cnt[15:8], 255);
    clear = 1'b1; trigger = 4'b0100; tick(); clear = 1'b0; trigger = '0;
    chk("drop1_clr", drop_cnt[15:8], 0);
    rx_q.delete();
    dst_rdy_i = 1'b1;
    drain(100);
    chk("clr_words", rx_q.size(), 7);

    // Stalls with the message input changing underneath.
    rx_q.delete();
    message[96 +: 32] = 32'hCAFE_F00D; vita_time = 64'h0123_4567_89AB_CDEF;
    trigger = 4'b1000; tick(); trigger = '0; tick();
    for (int i = 0; i < 40 && busy; i++) begin
      dst_rdy_i = (i % 2 == 0); message[96 +: 32] = $urandom; tick();
    end
    dst_rdy_i = 1'b1;
    chk("stall_words", rx_q.size(), 7);
    w = rx_q[3]; chk("stall_tics", w, 36'h0_0123_4567);
    w = rx_q[4]; chk("stall_tics2", w, 36'h0_89AB_CDEF);
    w = rx_q[5]; chk("stall_msg", w, 36'h0_CAFE_F00D);

    // Reset while the TICS word is presented.
    vita_time = 64'hFEED_0001_0000_0002;
    trigger = 4'b0100; tick(); trigger = '0; tick();
    tick(); tick(); tick();
    chk("at_tics", data_o, 36'h0_FEED_0001);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rdy", src_rdy_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_o, 0);
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 17 packets on ch0: sequence number wraps.
    for (int j = 0; j < 17; j++) begin
      rx_q.delete();
      trigger = 4'b0001; tick(); trigger = '0;
      drain(30);
      w = rx_q[1];
      chk($sformatf("wrap_seq%0d", j), w[19:16], j % 16);
    end

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        trigger[i] = ($urandom_range(0, 5) == 0);
        message[32*i +: 32]  = $urandom;
        streamid[32*i +: 32] = $urandom;
        seqnum[32*i +: 32]   = $urandom;
      end
      vita_time = {$urandom, $urandom};
      dst_rdy_i = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 79) == 0);
      tick();
    end
    trigger = '0; clear = 1'b0; dst_rdy_i = 1'b1;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
